// File: rtl/fetch_if.sv
// Fetch-stage bus: decoder/execute handshake plus the byte-wide instruction memory port.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_if #(
    parameter int ADDR_W = 8
);
    // Handshakes: en is a one-cycle request sampled only while idle; mem_valid
    // qualifies mem_data whenever mem_rd is high (may be the same cycle);
    // ready is a one-cycle pulse meaning inst/inst_pc were just updated.
    logic              en;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              mem_valid;
    logic [15:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] pc;
    logic              ready;
    logic              busy;
    logic              fault;

    modport master (
        input  en, jmp, jmp_addr, mem_data, mem_valid,
        output mem_addr, mem_rd, inst, inst_pc, pc, ready, busy, fault
    );

    modport slave (
        output en, jmp, jmp_addr, mem_data, mem_valid,
        input  mem_addr, mem_rd, inst, inst_pc, pc, ready, busy, fault
    );
endinterface

// File: rtl/fetch.sv
// bf8b instruction fetch: reads a big-endian 16-bit instruction as two bytes, owns the PC.
// Optional FETCH_ALIGN_CHECK_EN: odd jump targets are aligned down and raise a sticky fault.
module fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_if.master     bus,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_HI = 2'd1,
        S_RD_LO = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [7:0]        r_hi;
    logic [15:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_ready;
    logic              r_busy;
    logic              r_fault;

    logic [ADDR_W-1:0] w_jmp_target;
    logic              w_jmp_odd;
    logic [ADDR_W-1:0] w_pc_p1;
    logic [ADDR_W-1:0] w_pc_p2;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_jmp_target = {bus.jmp_addr[ADDR_W-1:1], 1'b0};
    assign w_jmp_odd    = bus.jmp_addr[0];
`else
    assign w_jmp_target = bus.jmp_addr;
    assign w_jmp_odd    = 1'b0;
`endif

    // Modulo 2^ADDR_W wrap falls out of the fixed-width adds.
    assign w_pc_p1 = r_pc + ADDR_W'(1);
    assign w_pc_p2 = r_pc + ADDR_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_rd   <= 1'b0;
            r_hi       <= 8'h00;
            r_inst     <= 16'h0000;
            r_inst_pc  <= RESET_PC;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.jmp) begin
                        r_pc    <= w_jmp_target;
                        r_fault <= r_fault | w_jmp_odd;
                    end else if (bus.en && !r_fault) begin
                        r_mem_addr <= r_pc;
                        r_mem_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RD_HI;
                    end
                end
                S_RD_HI, S_RD_LO: begin
                    // A redirect wins over any byte arriving in the same cycle.
                    if (bus.jmp) begin
                        r_pc     <= w_jmp_target;
                        r_fault  <= r_fault | w_jmp_odd;
                        r_mem_rd <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (bus.mem_valid) begin
                        if (r_state == S_RD_HI) begin
                            r_hi       <= bus.mem_data;
                            r_mem_addr <= w_pc_p1;
                            r_state    <= S_RD_LO;
                        end else begin
                            r_inst    <= {r_hi, bus.mem_data};
                            r_inst_pc <= r_pc;
                            r_pc      <= w_pc_p2;
                            r_mem_rd  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.inst     = r_inst;
    assign bus.inst_pc  = r_inst_pc;
    assign bus.pc       = r_pc;
    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.fault    = r_fault;
    assign o_state      = r_state;

endmodule
